bitnet_weight_stream_loader: RTL
================================

# bitnet_weight_stream_loader

AXI4-Stream-to-weight-port sequencer sitting directly upstream of the BitNet hybrid inference engine's weight-load port. It accepts 32-bit weight words from a DMA stream, packs each pair into one 54-bit ternary weight row, and walks layer and row counters. For every assembled row it issues a single-cycle load strobe with layer, row and data. This replaces per-row CPU register writes for bulk weight loading.

## Interface
Parameters:
- NUM_LAYERS, 2, layers to load (1..4)
- ROWS_PER_LAYER, 16, rows per layer (1..16)

Ports:
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset; asynchronous, active-low
- start  in  1  single-cycle pulse; begins a load session
- abort  in  1  single-cycle pulse; cancels the current session
- s_axis_tdata  in  32  weight word
- s_axis_tvalid  in  1  word valid
- s_axis_tready  out  1  loader accepts word
- s_axis_tlast  in  1  marks the final word of the session
- load_weight  out  1  single-cycle row-load strobe to the engine
- load_layer  out  2  layer index of the strobed row
- load_row  out  4  row index of the strobed row
- load_data  out  54  packed row, {hi[21:0], lo[31:0]}
- busy  out  1  session in progress
- done  out  1  sticky: all rows loaded cleanly
- error  out  1  sticky: session failed
- err_code  out  2  1 = early tlast, 2 = missing tlast, 3 = nonzero hi[31:22]

## Operation
- The FSM has five states: IDLE, LO, HI, ISSUE, ERR.
- IDLE:
  - start → LO.
  - On entry, layer and row counters are cleared, and done, error and err_code are cleared.
- LO:
  - tready=1.
  - On handshake, tdata latches into lo_reg → HI.
  - tlast on this handshake → ERR, code 1.
- HI:
  - tready=1.
  - On handshake, tdata latches into hi_reg.
  - If tdata[31:22] != 0 → ERR, code 3, and no strobe is issued.
  - Else if this is the final row (layer=NUM_LAYERS-1 and row=ROWS_PER_LAYER-1):
    - tlast=1 → ISSUE.
    - tlast=0 → ERR, code 2, and no strobe is issued.
  - Else if tlast=1 → ERR, code 1, and no strobe is issued.
  - Else → ISSUE.
- ISSUE:
  - tready=0, load_weight=1 for exactly one cycle.
  - load_layer and load_row carry the current counters; load_data = {hi_reg[21:0], lo_reg}.
  - Next state: final row → IDLE with done set; otherwise the row counter increments, wrapping to 0 and incrementing layer at ROWS_PER_LAYER-1 → LO.
- ERR:
  - tready=0 and error is held.
  - start → LO, clearing the error.
  - abort → IDLE, keeping error and err_code.
- busy=1 in LO, HI and ISSUE.
- load_layer, load_row and load_data are registered. They hold their last strobed values between strobes.
- Counter widths are fixed at 2 bits (layer) and 4 bits (row), so there is no overflow within the legal parameter range.
- start while busy is ignored.
- abort in LO, HI or ISSUE → IDLE next cycle:
  - A strobe pending in ISSUE is suppressed.
  - Counters are cleared and done is not set.
- abort and start in the same cycle: abort wins.
- abort in IDLE is a no-op.

## Timing
- Reset (async assert, synchronous-to-aclk deassert behaviour is the integrator's concern) forces all outputs to 0: tready, load_weight, load_layer, load_row, load_data, busy, done, error, err_code. The FSM goes to IDLE.
- Asserting reset mid-session drops the session immediately. No strobe is issued.
- tready is a registered function of state: high from the cycle after start until the HI handshake.
- Per row, minimum 3 cycles: LO accept, HI accept, ISSUE.
- The strobe appears on the cycle after the HI handshake.
- done and error rise in the same cycle the FSM leaves the final ISSUE or HI. They stay high until the next start or reset.
- Stalls (tvalid=0) may last arbitrarily long. State and counters are held.
- The loader never drops or duplicates an accepted word. tdata is sampled only when tvalid&tready.

## Test plan
- Clean load, NUM_LAYERS=2, ROWS_PER_LAYER=16, 64 words with tlast on word 64 and hi words with [31:22]=0 → 32 strobes, in order L0R0..L0R15, L1R0..L1R15, with correct data; done=1, error=0; last strobe to done takes 1 cycle.
- Random tvalid gaps (≈50 % duty) on the same data → identical strobe sequence and data; tready never high in ISSUE.
- tlast on word 7 (an LO word) → ERR, err_code=1, 3 strobes issued (rows 0–2), tready=0; a subsequent start restarts at L0R0.
- Final hi word without tlast → err_code=2, 31 strobes issued, done=0. Separately, hi word 0x0040_0000 at row 5 → err_code=3, row 5 not strobed.
- abort in the cycle a row would enter ISSUE → no strobe, busy=0 next cycle; abort+start in the same cycle → IDLE.
- aresetn pulsed low mid-session, between a HI handshake and its strobe → all outputs 0 immediately, no strobe; start afterwards loads from L0R0.

Source files
------------

// File: rtl/bitnet_weight_stream_loader.sv
// Streams 32-bit DMA words into 54-bit ternary weight rows for the BitNet engine.
// Each lo/hi word pair becomes one load strobe tagged with its layer/row, walking all rows per session.
module bitnet_weight_stream_loader #(
    parameter int NUM_LAYERS     = 2,
    parameter int ROWS_PER_LAYER = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic        load_weight,
    output logic [1:0]  load_layer,
    output logic [3:0]  load_row,
    output logic [53:0] load_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);

    localparam logic [1:0] LAST_LAYER = 2'(NUM_LAYERS - 1);
    localparam logic [3:0] LAST_ROW   = 4'(ROWS_PER_LAYER - 1);

    localparam logic [1:0] ERR_EARLY_LAST   = 2'd1;
    localparam logic [1:0] ERR_MISSING_LAST = 2'd2;
    localparam logic [1:0] ERR_HI_RANGE     = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_ISSUE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  layer_q, layer_d;
    logic [3:0]  row_q, row_d;
    logic [31:0] lo_q, lo_d;
    logic        tready_q, tready_d;
    logic        load_weight_q, load_weight_d;
    logic [1:0]  load_layer_q, load_layer_d;
    logic [3:0]  load_row_q, load_row_d;
    logic [53:0] load_data_q, load_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [1:0]  err_code_q, err_code_d;

    logic handshake;
    logic final_row;
    logic hi_out_of_range;

    // tready_q is high exactly in LO and HI, so this is the accepted-word condition
    assign handshake       = s_axis_tvalid & tready_q;
    assign final_row       = (layer_q == LAST_LAYER) && (row_q == LAST_ROW);
    assign hi_out_of_range = |s_axis_tdata[31:22];

    always_comb begin
        state_d      = state_q;
        layer_d      = layer_q;
        row_d        = row_q;
        lo_d         = lo_q;
        load_layer_d = load_layer_q;
        load_row_d   = load_row_q;
        load_data_d  = load_data_q;
        done_d       = done_q;
        error_d      = error_q;
        err_code_d   = err_code_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d    = S_LO;
                    layer_d    = '0;
                    row_d      = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = '0;
                end
            end

            S_LO: begin
                if (abort) begin
                    state_d = S_IDLE;
                    layer_d = '0;
                    row_d   = '0;
                end else if (handshake) begin
                    lo_d = s_axis_tdata;
                    if (s_axis_tlast) begin
                        state_d    = S_ERR;
                        error_d    = 1'b1;
                        err_code_d = ERR_EARLY_LAST;
                    end else begin
                        state_d = S_HI;
                    end
                end
            end

            S_HI: begin
                if (abort) begin
                    state_d = S_IDLE;
                    layer_d = '0;
                    row_d   = '0;
                end else if (handshake) begin
                    if (hi_out_of_range) begin
                        state_d    = S_ERR;
                        error_d    = 1'b1;
                        err_code_d = ERR_HI_RANGE;
                    end else if (final_row != s_axis_tlast) begin
                        state_d    = S_ERR;
                        error_d    = 1'b1;
                        err_code_d = final_row ? ERR_MISSING_LAST : ERR_EARLY_LAST;
                    end else begin
                        // Row fields are captured here so the strobe lands the next cycle
                        state_d      = S_ISSUE;
                        load_layer_d = layer_q;
                        load_row_d   = row_q;
                        load_data_d  = {s_axis_tdata[21:0], lo_q};
                    end
                end
            end

            S_ISSUE: begin
                if (abort || final_row) begin
                    state_d = S_IDLE;
                    layer_d = '0;
                    row_d   = '0;
                    done_d  = !abort;
                end else begin
                    state_d = S_LO;
                    if (row_q == LAST_ROW) begin
                        row_d   = '0;
                        layer_d = layer_q + 2'd1;
                    end else begin
                        row_d = row_q + 4'd1;
                    end
                end
            end

            S_ERR: begin
                if (abort) begin
                    state_d = S_IDLE;
                    layer_d = '0;
                    row_d   = '0;
                end else if (start) begin
                    state_d    = S_LO;
                    layer_d    = '0;
                    row_d      = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
                layer_d = '0;
                row_d   = '0;
            end
        endcase

        // Registered outputs derived from the next state
        tready_d      = (state_d == S_LO) || (state_d == S_HI);
        busy_d        = (state_d == S_LO) || (state_d == S_HI) || (state_d == S_ISSUE);
        load_weight_d = (state_d == S_ISSUE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= S_IDLE;
            layer_q       <= '0;
            row_q         <= '0;
            lo_q          <= '0;
            tready_q      <= 1'b0;
            load_weight_q <= 1'b0;
            load_layer_q  <= '0;
            load_row_q    <= '0;
            load_data_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            err_code_q    <= '0;
        end else begin
            state_q       <= state_d;
            layer_q       <= layer_d;
            row_q         <= row_d;
            lo_q          <= lo_d;
            tready_q      <= tready_d;
            load_weight_q <= load_weight_d;
            load_layer_q  <= load_layer_d;
            load_row_q    <= load_row_d;
            load_data_q   <= load_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            err_code_q    <= err_code_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign load_weight   = load_weight_q;
    assign load_layer    = load_layer_q;
    assign load_row      = load_row_q;
    assign load_data     = load_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_code      = err_code_q;

endmodule
